// File: rtl/wb_sequencer_if.sv
// Bundle of decoder, data-memory handshake and writeback-control signals
// shared by the writeback sequencer and its environment.
interface wb_sequencer_if;
  // Decoder side
  logic       InstrValid;
  logic [1:0] ResultSrcD;
  logic       RegWriteD;
  logic       MemReadD;
  logic       MemWriteD;
  // Handshake: MemReq is held high for every MEM cycle; MemAck completes the
  // access on any edge where MemReq is high and is ignored whenever it is low.
  logic       MemAck;
  logic       MemReq;
  logic       MemWE;
  // Writeback control
  logic [1:0] ResultSrc;
  logic       RegWrite;
  logic       PCEn;
  logic       BusFault;

  modport master (
    input  InstrValid, ResultSrcD, RegWriteD, MemReadD, MemWriteD, MemAck,
    output MemReq, MemWE, ResultSrc, RegWrite, PCEn, BusFault
  );

  modport slave (
    output InstrValid, ResultSrcD, RegWriteD, MemReadD, MemWriteD, MemAck,
    input  MemReq, MemWE, ResultSrc, RegWrite, PCEn, BusFault
  );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback / memory-access sequencer: single-cycle commit for ALU-type
// instructions, req/ack stretch for loads and stores, sticky timeout fault.
module wb_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_sequencer_if.master       bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM   = 2'd1,
    S_WB    = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          is_load_q, is_load_d;
  logic          is_store_q, is_store_d;
  logic          wr_q, wr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
      wr_q       <= wr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    is_load_d     = is_load_q;
    is_store_d    = is_store_q;
    wr_d          = wr_q;
    bus.MemReq    = 1'b0;
    bus.MemWE     = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.RegWrite  = 1'b0;
    bus.PCEn      = 1'b0;
    bus.BusFault  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.InstrValid) begin
          bus.ResultSrc = bus.ResultSrcD;
          if (bus.MemReadD || bus.MemWriteD) begin
            // A load takes priority when both strobes are set.
            is_load_d  = bus.MemReadD;
            is_store_d = bus.MemWriteD & ~bus.MemReadD;
            wr_d       = bus.RegWriteD & bus.MemReadD;
            timer_d    = TW'(1);
            state_d    = S_MEM;
          end else begin
            bus.RegWrite = bus.RegWriteD;
            bus.PCEn     = 1'b1;
          end
        end
      end
      S_MEM: begin
        bus.MemReq    = 1'b1;
        bus.MemWE     = is_store_q & ~is_load_q;
        bus.ResultSrc = 2'b01;
        // Ack in the last permitted cycle still completes the access.
        if (bus.MemAck) begin
          state_d = S_WB;
        end else if (timer_q == TMAX) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = wr_q;
        bus.PCEn      = 1'b1;
        is_load_d     = 1'b0;
        is_store_d    = 1'b0;
        wr_d          = 1'b0;
        timer_d       = '0;
        state_d       = S_IDLE;
      end
      S_FAULT: begin
        bus.BusFault = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Randomized bench for wb_sequencer: each instruction is expanded into its
// per-cycle expected output trace and compared against the DUT cycle by cycle.
module tb_wb_sequencer;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  wb_sequencer_if bus();

  wb_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: packed {MemReq, MemWE, ResultSrc[1:0], RegWrite, PCEn, BusFault}
  logic [6:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pk(input logic mreq, input logic mwe, input logic [1:0] rs,
                                    input logic rw, input logic pc, input logic bf);
    return {mreq, mwe, rs, rw, pc, bf};
  endfunction

  function automatic logic [6:0] outs();
    return {bus.MemReq, bus.MemWE, bus.ResultSrc, bus.RegWrite, bus.PCEn, bus.BusFault};
  endfunction

  // Driver: called just after a rising edge; drives, samples at the falling edge.
  task automatic step(input logic iv, input logic [1:0] rsd, input logic rwd,
                      input logic mrd, input logic mwd, input logic ack, input string tag);
    logic [6:0] e;
    bus.InstrValid = iv;
    bus.ResultSrcD = rsd;
    bus.RegWriteD  = rwd;
    bus.MemReadD   = mrd;
    bus.MemWriteD  = mwd;
    bus.MemAck     = ack;
    @(negedge clk);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
    check(tag, {25'd0, outs()}, {25'd0, e});
    @(posedge clk);
    #1;
  endtask

  // Random decoder inputs while the sequencer is busy; they must be ignored.
  task automatic step_junk(input logic ack, input string tag);
    step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ack, tag);
  endtask

  // Reference model: expands one instruction into its expected cycle trace.
  // k = cycle of MEM in which MemAck arrives (1..TIMEOUT), 0 = never.
  task automatic run_instr(input logic iv, input logic [1:0] rsd, input logic rwd,
                           input logic mr, input logic mw, input int k, input string tag);
    if (!iv) begin
      exp_q.push_back(pk(0, 0, 2'b00, 0, 0, 0));
      step(0, rsd, rwd, mr, mw, 1'($urandom_range(0, 1)), {tag, "_noinstr"});
    end else if (!(mr || mw)) begin
      exp_q.push_back(pk(0, 0, rsd, rwd, 1, 0));
      step(1, rsd, rwd, 0, 0, 1'($urandom_range(0, 1)), {tag, "_commit"});
    end else begin
      exp_q.push_back(pk(0, 0, rsd, 0, 0, 0));
      step(1, rsd, rwd, mr, mw, 1'($urandom_range(0, 1)), {tag, "_issue"});
      for (int j = 1; j <= TIMEOUT; j++) begin
        exp_q.push_back(pk(1, mw & ~mr, 2'b01, 0, 0, 0));
        step_junk(j == k, $sformatf("%s_mem%0d", tag, j));
        if (j == k) break;
      end
      if (k != 0) begin
        exp_q.push_back(pk(0, 0, 2'b01, rwd & mr, 1, 0));
        step_junk(1'($urandom_range(0, 1)), {tag, "_wb"});
      end else begin
        for (int j = 0; j < 4; j++) begin
          exp_q.push_back(pk(0, 0, 2'b00, 0, 0, 1));
          step_junk(1'b1, $sformatf("%s_fault%0d", tag, j));
        end
      end
    end
  endtask

  initial begin
    int kind;
    int k;
    logic [1:0] rsd;
    logic rwd, mr, mw;

    bus.InstrValid = 0; bus.ResultSrcD = 0; bus.RegWriteD = 0;
    bus.MemReadD = 0; bus.MemWriteD = 0; bus.MemAck = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {25'd0, outs()}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    run_instr(0, 2'b11, 1, 1, 0, 1, "idle_after_reset");
    run_instr(1, 2'b00, 1, 0, 0, 1, "alu");
    run_instr(1, 2'b10, 1, 0, 0, 1, "jal");
    run_instr(1, 2'b11, 0, 0, 0, 1, "auipc_nowr");
    run_instr(1, 2'b01, 1, 1, 0, 3, "load_k3");
    run_instr(1, 2'b00, 0, 0, 1, 1, "store_k1");
    run_instr(1, 2'b01, 1, 1, 0, TIMEOUT, "load_kmax");
    run_instr(1, 2'b01, 1, 1, 1, 2, "load_store_both");
    run_instr(1, 2'b01, 1, 1, 0, 1, "b2b_load_a");
    run_instr(1, 2'b00, 1, 0, 1, 2, "b2b_store_b");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      rsd  = 2'($urandom_range(0, 3));
      rwd  = 1'($urandom_range(0, 1));
      k    = $urandom_range(1, TIMEOUT);
      case (kind)
        0: begin mr = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1)); end
        1: begin mr = 0; mw = 0; end
        2: begin mr = 1; mw = 0; end
        3: begin mr = 0; mw = 1; end
        default: begin mr = 1; mw = 1; end
      endcase
      run_instr(kind != 0, rsd, rwd, mr, mw, k, $sformatf("rnd%0d", n));
    end

    // Reset pulse in the middle of an access.
    exp_q.push_back(pk(0, 0, 2'b01, 0, 0, 0));
    step(1, 2'b01, 1, 1, 0, 0, "rstmem_issue");
    exp_q.push_back(pk(1, 0, 2'b01, 0, 0, 0));
    step(0, 2'b00, 0, 0, 0, 0, "rstmem_mem1");
    #2 rst_n = 1'b0;
    #1 check("rstmem_memreq_drop", {31'd0, bus.MemReq}, 32'd0);
    check("rstmem_outs", {25'd0, outs()}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_instr(0, 2'b00, 0, 0, 0, 1, "rstmem_idle");
    run_instr(1, 2'b10, 1, 0, 0, 1, "rstmem_alu");

    // Timeout into the sticky fault, then recovery by reset.
    run_instr(1, 2'b01, 1, 1, 0, 0, "timeout");
    rst_n = 1'b0;
    #1 check("fault_cleared", {31'd0, bus.BusFault}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_instr(1, 2'b00, 1, 0, 0, 1, "post_fault_alu");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Writeback and memory-access sequencer for the single-cycle RISC-V core. It drives the 2-bit result-source select of the register-file write-data mux (00 ALU, 01 data memory, 10 PC+4, 11 PC+imm), the register-file write enable and the PC advance enable. Non-memory instructions commit in one cycle. Loads and stores are stretched over a variable-latency request/acknowledge handshake with the data memory. A timeout watchdog flags a hung bus.

## Interface
Parameters:
- TIMEOUT, default 16: maximum number of MEM cycles to wait for MemAck before faulting; legal range 1..255.
- TW, default $clog2(TIMEOUT+1): timer width, derived.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- InstrValid  in  1  decoded instruction present this cycle.
- ResultSrcD  in  2  result source requested by the decoder.
- RegWriteD  in  1  decoder register-write request.
- MemReadD  in  1  instruction is a load.
- MemWriteD  in  1  instruction is a store.
- MemAck  in  1  data memory completion; sampled only in MEM.
- MemReq  out  1  memory request; high for every MEM cycle.
- MemWE  out  1  store strobe; valid while MemReq is high.
- ResultSrc  out  2  write-data mux select.
- RegWrite  out  1  register-file write enable.
- PCEn  out  1  PC/instruction advance enable.
- BusFault  out  1  sticky timeout flag.

## Operation
- States are IDLE, MEM, WB and FAULT. State is registered. Outputs are combinational from the state, the latched flags and, in IDLE only, the decoder inputs.
- IDLE, with InstrValid=1 and MemReadD=MemWriteD=0:
  - ResultSrc=ResultSrcD, RegWrite=RegWriteD, PCEn=1.
  - The state stays IDLE.
- IDLE, with InstrValid=1 and (MemReadD or MemWriteD):
  - Outputs: RegWrite=0, PCEn=0, ResultSrc=ResultSrcD, MemReq=0.
  - Latched at the edge: is_load=MemReadD, is_store=MemWriteD & ~MemReadD, wr=RegWriteD & MemReadD.
  - Timer is loaded with 1. Next state is MEM.
- MemReadD and MemWriteD both high: treated as a load, and MemWE stays 0.
- IDLE with InstrValid=0: all outputs are 0.
- MEM:
  - Outputs: MemReq=1, MemWE=is_store, ResultSrc=01, RegWrite=0, PCEn=0.
  - Decoder inputs are ignored.
  - If MemAck=1, next state is WB.
  - If MemAck=0 and timer==TIMEOUT, next state is FAULT.
  - Otherwise the timer increments and the state stays MEM.
  - MemAck in the final allowed cycle wins over the timeout.
- WB:
  - Outputs: ResultSrc=01, RegWrite=wr, PCEn=1, MemReq=0.
  - Next state is IDLE. Latched flags are cleared at that edge.
- FAULT:
  - Outputs: MemReq=0, MemWE=0, RegWrite=0, PCEn=0, ResultSrc=00, BusFault=1.
  - This state is only left by reset.
- MemAck outside MEM is ignored and has no effect on state.

## Timing
- Reset values:
  - State IDLE; timer 0; is_load, is_store and wr all 0; BusFault 0.
  - With InstrValid low, every output is 0, including ResultSrc=00.
- Reset asserted mid-MEM: MemReq falls asynchronously with rst_n, and the access is abandoned.
- Non-memory instruction: zero added latency; it commits in its single IDLE cycle.
- Memory instruction acknowledged in its k-th MEM cycle (1 ≤ k ≤ TIMEOUT):
  - Total occupancy is k+2 cycles: one IDLE, k MEM, one WB.
  - PCEn is high only in the WB cycle.
- Timeout: after TIMEOUT MEM cycles with no acknowledge, BusFault rises on the next edge.
- MemReq is never high for more than TIMEOUT consecutive cycles.
- Back-to-back memory instructions: WB, then IDLE (new instruction), then MEM. There is no bubble beyond the IDLE cycle.
- A store clears wr, so RegWrite is 0 in the store's WB cycle.

## Test plan
- Reset with InstrValid=0, then release: every output stays 0 and BusFault=0. Pulse rst_n low mid-MEM: MemReq drops in the same cycle and the state returns to IDLE.
- ALU instruction (InstrValid=1, ResultSrcD=00, RegWriteD=1), then JAL (ResultSrcD=10): each commits in one cycle with ResultSrc mirroring the decoder, RegWrite=1 and PCEn=1.
- Load (MemReadD=1, RegWriteD=1, ResultSrcD=01) with MemAck on the 3rd MEM cycle: MemReq high for exactly 3 cycles, then WB with ResultSrc=01, RegWrite=1, PCEn=1; 5 cycles total.
- Store (MemWriteD=1, RegWriteD=0) with immediate ack: MemReq=1 and MemWE=1 for 1 cycle, then WB with RegWrite=0 and PCEn=1.
- Load with TIMEOUT=16:
  - MemAck in the 16th MEM cycle completes normally.
  - With no ack, FAULT is entered after 16 MEM cycles; BusFault=1 and PCEn=0 until reset, and a late MemAck is ignored.
- MemReadD=MemWriteD=1, plus spurious MemAck pulses in IDLE and WB: the access is handled as a load with MemWE=0, and the spurious pulses cause no state change.
